// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential multiplier.
// FSM state encoding and counter sizing live here.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mult_state_t;

    // Bits needed to hold a count from w down to 0.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/adder.sv
// Plain unsigned adder, shared by every iteration.
// Width n is the full result width; no carry-out.
module adder #(
    parameter int n = 33
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n-1:0] s
);

    assign s = a + b;

endmodule

// File: rtl/mult_seq.sv
// Sequential shift-and-add n x n -> 2n unsigned multiplier.
// One add per cycle; start/busy/done handshake for stalling.
module mult_seq
    import mult_pkg::*;
#(
    parameter int n = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [n-1:0]   A,
    input  logic [n-1:0]   B,
    output logic           busy,
    output logic           done,
    output logic [2*n-1:0] P
);

    localparam int CW = cnt_width(n);

    mult_state_t state;
    mult_state_t state_nx;

    logic [n-1:0]  mcand;
    logic [n-1:0]  hi;
    logic [n-1:0]  lo;
    logic [CW-1:0] cnt;
    logic [n:0]    hi_ext;
    logic [n:0]    addend;
    logic [n:0]    sum;
    logic          accept;
    logic          last;

    // A request is only taken when no product is in flight.
    assign accept = start && (state != RUN);
    assign last   = (state == RUN) && (cnt == CW'(1));

    // Partial product: multiplicand gated by the current multiplier bit.
    assign hi_ext = {1'b0, hi};
    assign addend = lo[0] ? {1'b0, mcand} : '0;

    adder #(
        .n(n + 1)
    ) u_adder (
        .a(hi_ext),
        .b(addend),
        .s(sum)
    );

    // Next-state decode; start is ignored while running.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nx = RUN;
            end
            RUN: begin
                if (cnt == CW'(1))
                    state_nx = DONE;
            end
            DONE: begin
                state_nx = start ? RUN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register with registered busy/done decoded from next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx == RUN);
            done  <= (state_nx == DONE);
        end
    end

    // Operand capture and one shift-add step per RUN cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
        end else if (accept) begin
            mcand <= A;
            hi    <= '0;
            lo    <= B;
            cnt   <= CW'(n);
        end else if (state == RUN) begin
            hi  <= sum[n:1];
            lo  <= {sum[0], lo[n-1:1]};
            cnt <= cnt - CW'(1);
        end
    end

    // Product register, written only on the final iteration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            P <= '0;
        else if (last)
            P <= {sum[n:1], sum[0], lo[n-1:1]};
    end

endmodule

// File: tb/tb_mult_seq.sv
// Scoreboard bench for mult_seq: reference products and
// expected handshake timing come from a cycle-level model.
module tb_mult_seq;

    localparam int N = 32;

    typedef struct {
        longint unsigned prod;
        int unsigned     acc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [N-1:0]  A = '0;
    logic [N-1:0]  B = '0;
    logic          busy;
    logic          done;
    logic [2*N-1:0] P;

    int checks = 0;
    int errors = 0;

    exp_t            sb[$];
    int              m_left = 0;
    bit              exp_done = 1'b0;
    longint unsigned exp_p = 0;
    int unsigned     cyc = 0;

    mult_seq #(
        .n(N)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .A(A),
        .B(B),
        .busy(busy),
        .done(done),
        .P(P)
    );

    always #5 clk = ~clk;

    // Reference model: n busy cycles per accepted request, then one
    // done cycle during which a new request may be taken.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left   = 0;
            exp_done = 1'b0;
            exp_p    = 0;
            sb.delete();
        end else begin
            cyc++;
            exp_done = (m_left == 1);
            if (m_left != 0) begin
                m_left--;
            end else if (start) begin
                sb.push_back('{longint'(A) * longint'(B), cyc});
                m_left = N;
            end
        end
    end

    // Monitor: compare outputs each cycle, pop on every done.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (busy !== (m_left != 0)) begin
                errors++;
                $display("FAIL busy got %0b want %0b cyc %0d",
                         busy, m_left != 0, cyc);
            end
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL done got %0b want %0b cyc %0d",
                         done, exp_done, cyc);
            end
            if (done === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_done got 1 want 0 cyc %0d",
                             cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    exp_p = e.prod;
                    checks++;
                    if (cyc - e.acc != N) begin
                        errors++;
                        $display("FAIL latency got %0d want %0d",
                                 cyc - e.acc, N);
                    end
                end
            end
            checks++;
            if (P !== exp_p) begin
                errors++;
                $display("FAIL P got %h want %h cyc %0d", P, exp_p, cyc);
            end
        end
    end

    task automatic chk(input string name, input longint unsigned got,
                       input longint unsigned want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_quiet();
        int k;
        k = 0;
        while ((sb.size() != 0 || m_left != 0 || exp_done) && k < 400) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 400) begin
            errors++;
            $display("FAIL timeout got %0d pending want 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int k;
        logic [N-1:0] ra;
        logic [N-1:0] rb;

        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_P", P, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        issue(3, 5);
        wait_quiet();
        chk("p_3x5", P, 15);
        repeat (5) @(negedge clk);
        chk("p_hold", P, 15);

        issue('1, '1);
        wait_quiet();
        chk("p_ones", P, 64'hFFFF_FFFE_0000_0001);
        issue(0, 32'hDEAD_BEEF);
        wait_quiet();
        chk("p_zero", P, 0);
        issue(1, 32'h8000_0000);
        wait_quiet();
        chk("p_msb", P, 64'h0000_0000_8000_0000);

        issue(7, 6);
        repeat (8) @(negedge clk);
        A = 9;
        B = 9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_quiet();
        chk("p_ignore", P, 42);

        @(negedge clk);
        A = 2;
        B = 3;
        start = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!exp_done && k < 100);
        chk("b2b_first", P, 6);
        A = 4;
        B = 5;
        @(negedge clk);
        start = 1'b0;
        wait_quiet();
        chk("b2b_second", P, 20);

        @(negedge clk);
        A = 100;
        B = 100;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 0);
        chk("abort_done", 64'(done), 0);
        chk("abort_P", P, 0);
        @(negedge clk);
        reset = 1'b0;
        issue(12, 12);
        wait_quiet();
        chk("p_after_rst", P, 144);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 15) == 0) ra = '1;
            if ($urandom_range(0, 15) == 0) rb = '1;
            issue(ra, rb);
            wait_quiet();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
